// File: rtl/req_queue_aged_if.sv
// Request queue handshake bundle: producer side (in_*) and consumer side (out_*).
interface req_queue_aged_if #(
    parameter int unsigned OP_W   = 2,
    parameter int unsigned ADDR_W = 33,
    parameter int unsigned AGE_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_opcode;
    logic [ADDR_W-1:0] in_address;

    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_opcode;
    logic [ADDR_W-1:0] out_address;
    logic [AGE_W-1:0]  out_age;

    // Environment view: offers operations, accepts the head.
    modport master (
        output in_valid, in_opcode, in_address, out_ready,
        input  in_ready, out_valid, out_opcode, out_address, out_age
    );

    // Queue view.
    modport slave (
        input  in_valid, in_opcode, in_address, out_ready,
        output in_ready, out_valid, out_opcode, out_address, out_age
    );
endinterface

// File: rtl/req_queue_aged.sv
// In-order request queue that holds each entry for at least MIN_AGE cycles
// before offering it, with saturating per-entry age counters.
module req_queue_aged #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 33,
    parameter int unsigned OP_W    = 2,
    parameter int unsigned AGE_W   = 8,
    parameter int unsigned MIN_AGE = 100,
    parameter int unsigned PTR_W   = $clog2(DEPTH) + 1
) (
    input  logic              CPU_clk,
    input  logic              rst_n,
    input  logic              flush,
    req_queue_aged_if.slave   q,
    output logic [PTR_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned      IDX_W     = PTR_W - 1;
    localparam logic [AGE_W-1:0] AGE_MAX   = {AGE_W{1'b1}};
    localparam logic [AGE_W-1:0] MIN_AGE_V = AGE_W'(MIN_AGE);

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [ADDR_W-1:0] address;
    } entry_t;

    // Parameter sanity: derived pointer width, power-of-two depth, threshold range.
    if (PTR_W != $clog2(DEPTH) + 1) begin : g_bad_ptr_w
        $fatal(1, "req_queue_aged: PTR_W must equal $clog2(DEPTH)+1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "req_queue_aged: DEPTH must be a power of two >= 2");
    end
    if ((MIN_AGE >> AGE_W) != 0) begin : g_bad_min_age
        $fatal(1, "req_queue_aged: MIN_AGE exceeds the age counter range");
    end

    entry_t           data_q  [DEPTH];
    logic [AGE_W-1:0] age_q   [DEPTH];
    logic             valid_q [DEPTH];

    logic [PTR_W-1:0] wr_p;
    logic [PTR_W-1:0] rd_p;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [AGE_W-1:0] head_age;
    logic             head_aged;
    logic             head_ok;
    logic             push;
    logic             pop;

    assign wr_idx   = wr_p[IDX_W-1:0];
    assign rd_idx   = rd_p[IDX_W-1:0];
    assign head_age = age_q[rd_idx];

    // A zero threshold makes every present head eligible.
    if (MIN_AGE == 0) begin : g_no_min_age
        assign head_aged = 1'b1;
    end else begin : g_min_age
        assign head_aged = (head_age >= MIN_AGE_V);
    end

    assign empty   = (wr_p == rd_p);
    assign full    = (wr_idx == rd_idx) && (wr_p[PTR_W-1] != rd_p[PTR_W-1]);
    assign count   = wr_p - rd_p;
    assign head_ok = !empty && head_aged;
    assign push    = q.in_valid && !full;
    assign pop     = head_ok && q.out_ready;

    // Head presentation; everything reads zero when the queue is empty.
    always_comb begin
        q.in_ready    = !full;
        q.out_valid   = head_ok;
        q.out_opcode  = '0;
        q.out_address = '0;
        q.out_age     = '0;
        if (!empty) begin
            q.out_opcode  = data_q[rd_idx].opcode;
            q.out_address = data_q[rd_idx].address;
            q.out_age     = head_age;
        end
    end

    // Read/write pointers; flush returns both to the origin.
    always_ff @(posedge CPU_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_p <= '0;
            rd_p <= '0;
        end else if (flush) begin
            wr_p <= '0;
            rd_p <= '0;
        end else begin
            if (push) begin
                wr_p <= wr_p + PTR_W'(1);
            end
            if (pop) begin
                rd_p <= rd_p + PTR_W'(1);
            end
        end
    end

    // Entry storage: write on push, retire on pop, otherwise age valid entries.
    // Push and pop never target the same slot: that would need full and non-full at once.
    always_ff @(posedge CPU_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i]  <= '0;
                age_q[i]   <= '0;
                valid_q[i] <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                age_q[i]   <= '0;
                valid_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (push && (wr_idx == IDX_W'(i))) begin
                    data_q[i].opcode  <= q.in_opcode;
                    data_q[i].address <= q.in_address;
                    age_q[i]          <= '0;
                    valid_q[i]        <= 1'b1;
                end else if (pop && (rd_idx == IDX_W'(i))) begin
                    age_q[i]   <= '0;
                    valid_q[i] <= 1'b0;
                end else if (valid_q[i] && (age_q[i] != AGE_MAX)) begin
                    age_q[i] <= age_q[i] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_req_queue_aged.sv
// Directed bench for req_queue_aged: default-threshold instance plus a MIN_AGE=0 instance.
module tb_req_queue_aged;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 33;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned AGE_W  = 8;
    localparam int unsigned PTR_W  = 5;

    logic             CPU_clk = 1'b0;
    logic             rst_n;
    logic             flush_a;
    logic             flush_b;
    logic [PTR_W-1:0] count_a;
    logic [PTR_W-1:0] count_b;
    logic             full_a;
    logic             full_b;
    logic             empty_a;
    logic             empty_b;

    int n_checks = 0;
    int n_errors = 0;

    req_queue_aged_if #(.OP_W(OP_W), .ADDR_W(ADDR_W), .AGE_W(AGE_W)) ia ();
    req_queue_aged_if #(.OP_W(OP_W), .ADDR_W(ADDR_W), .AGE_W(AGE_W)) ib ();

    req_queue_aged #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OP_W(OP_W), .AGE_W(AGE_W), .MIN_AGE(100), .PTR_W(PTR_W)
    ) dut_a (
        .CPU_clk (CPU_clk),
        .rst_n   (rst_n),
        .flush   (flush_a),
        .q       (ia),
        .count   (count_a),
        .full    (full_a),
        .empty   (empty_a)
    );

    req_queue_aged #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OP_W(OP_W), .AGE_W(AGE_W), .MIN_AGE(0), .PTR_W(PTR_W)
    ) dut_b (
        .CPU_clk (CPU_clk),
        .rst_n   (rst_n),
        .flush   (flush_b),
        .q       (ib),
        .count   (count_b),
        .full    (full_b),
        .empty   (empty_b)
    );

    always #5 CPU_clk = ~CPU_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CPU_clk);
        #1;
    endtask

    // Wait (bounded) for an eligible head on dut_a, check its address, pop it.
    task automatic pop_expect_a(input string tag, input logic [ADDR_W-1:0] exp_addr);
        int waited = 0;
        while (!ia.out_valid && waited < 300) begin
            tick();
            waited++;
        end
        if (!ia.out_valid) begin
            check({tag, "_timeout"}, 64'(ia.out_valid), 64'(1));
        end else begin
            check(tag, 64'(ia.out_address), 64'(exp_addr));
            ia.out_ready = 1'b1;
            tick();
            ia.out_ready = 1'b0;
        end
    endtask

    task automatic wait_head_a();
        int waited = 0;
        while (!ia.out_valid && waited < 300) begin
            tick();
            waited++;
        end
        check("head_eligible_wait", 64'(ia.out_valid), 64'(1));
    endtask

    task automatic push_a(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] addr);
        ia.in_valid   = 1'b1;
        ia.in_opcode  = op;
        ia.in_address = addr;
        tick();
        ia.in_valid   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int max_cnt;
        logic [ADDR_W-1:0] got [$];
        logic [ADDR_W-1:0] exp_q [$];

        rst_n = 1'b0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        ia.in_valid = 1'b0; ia.in_opcode = '0; ia.in_address = '0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_opcode = '0; ib.in_address = '0; ib.out_ready = 1'b0;

        // Reset state.
        #12;
        check("rst_in_ready", 64'(ia.in_ready), 64'(1));
        check("rst_out_valid", 64'(ia.out_valid), 64'(0));
        check("rst_count", 64'(count_a), 64'(0));
        check("rst_empty", 64'(empty_a), 64'(1));
        check("rst_full", 64'(full_a), 64'(0));
        check("rst_b_empty", 64'(empty_b), 64'(1));
        check("rst_b_count", 64'(count_b), 64'(0));
        check("rst_b_full", 64'(full_b), 64'(0));
        check("rst_b_opcode", 64'(ib.out_opcode), 64'(0));
        check("rst_b_age", 64'(ib.out_age), 64'(0));
        #1 rst_n = 1'b1;
        tick();

        // Single push, MIN_AGE=100, downstream always ready.
        ia.out_ready = 1'b1;
        push_a(2'd2, 33'h1_0000_0040);
        seen = 0;
        if (ia.out_valid) seen++;
        check("t1_count_after_push", 64'(count_a), 64'(1));
        check("t1_age0", 64'(ia.out_age), 64'(0));
        for (int k = 1; k <= 99; k++) begin
            tick();
            if (ia.out_valid) seen++;
        end
        check("t1_early_valid", 64'(seen), 64'(0));
        check("t1_age99", 64'(ia.out_age), 64'(99));
        tick();
        check("t1_valid_at100", 64'(ia.out_valid), 64'(1));
        check("t1_age100", 64'(ia.out_age), 64'(100));
        check("t1_opcode", 64'(ia.out_opcode), 64'(2));
        check("t1_address", 64'(ia.out_address), 64'(33'h1_0000_0040));
        tick();
        check("t1_empty_after_pop", 64'(empty_a), 64'(1));
        check("t1_count_after_pop", 64'(count_a), 64'(0));
        check("t1_address_empty", 64'(ia.out_address), 64'(0));
        ia.out_ready = 1'b0;

        // Fill to DEPTH under backpressure; one more push is ignored.
        for (int i = 0; i < 16; i++) begin
            push_a(OP_W'(i), ADDR_W'(32'h100 + i));
        end
        check("t2_full", 64'(full_a), 64'(1));
        check("t2_in_ready", 64'(ia.in_ready), 64'(0));
        check("t2_count16", 64'(count_a), 64'(16));
        push_a(2'd3, 33'h1_DEAD);
        check("t2_count_after_17th", 64'(count_a), 64'(16));
        for (int i = 0; i < 16; i++) begin
            pop_expect_a($sformatf("t2_order%0d", i), ADDR_W'(32'h100 + i));
        end
        check("t2_empty_after_drain", 64'(empty_a), 64'(1));

        // Simultaneous push/pop at count 15 (write slot wraps), then at count 16.
        for (int i = 0; i < 15; i++) begin
            push_a(2'd1, ADDR_W'(32'h200 + i));
        end
        wait_head_a();
        check("t3_head_before", 64'(ia.out_address), 64'(33'h200));
        ia.out_ready = 1'b1;
        push_a(2'd1, 33'h2F0);
        ia.out_ready = 1'b0;
        check("t3_count15", 64'(count_a), 64'(15));
        push_a(2'd1, 33'h2F1);
        check("t3_count16", 64'(count_a), 64'(16));
        wait_head_a();
        ia.out_ready = 1'b1;
        push_a(2'd1, 33'h2FF);
        ia.out_ready = 1'b0;
        check("t3_count_full_pushpop", 64'(count_a), 64'(15));
        check("t3_not_full", 64'(full_a), 64'(0));
        for (int i = 2; i < 15; i++) exp_q.push_back(ADDR_W'(32'h200 + i));
        exp_q.push_back(33'h2F0);
        exp_q.push_back(33'h2F1);
        foreach (exp_q[i]) begin
            pop_expect_a($sformatf("t3_order%0d", i), exp_q[i]);
        end
        check("t3_empty", 64'(empty_a), 64'(1));

        // Streaming through the MIN_AGE=0 instance, three times around the buffer.
        ib.out_ready = 1'b1;
        max_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            ib.in_valid   = 1'b1;
            ib.in_address = ADDR_W'(i);
            if (i == 0) begin
                #1;
                check("t4_no_bypass", 64'(ib.out_valid), 64'(0));
            end
            tick();
            if (ib.out_valid) got.push_back(ib.out_address);
            if (int'(count_b) > max_cnt) max_cnt = int'(count_b);
        end
        ib.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ib.out_valid) got.push_back(ib.out_address);
        end
        check("t4_received", 64'(got.size()), 64'(48));
        check("t4_max_count", 64'(max_cnt), 64'(1));
        check("t4_empty", 64'(empty_b), 64'(1));
        foreach (got[i]) begin
            check($sformatf("t4_order%0d", i), 64'(got[i]), 64'(i));
        end
        ib.out_ready = 1'b0;

        // Age saturation under long backpressure.
        push_a(2'd1, 33'h3AA);
        for (int j = 1; j <= 400; j++) begin
            tick();
            if (j == 254) check("t5_age254", 64'(ia.out_age), 64'(254));
        end
        check("t5_age_sat", 64'(ia.out_age), 64'(255));
        check("t5_valid_sat", 64'(ia.out_valid), 64'(1));
        ia.out_ready = 1'b1;
        tick();
        ia.out_ready = 1'b0;
        check("t5_single_pop", 64'(count_a), 64'(0));
        check("t5_empty", 64'(empty_a), 64'(1));

        // Asynchronous reset with five aged entries held.
        for (int i = 0; i < 5; i++) begin
            push_a(2'd3, ADDR_W'(32'h400 + i));
        end
        for (int j = 0; j < 105; j++) tick();
        check("t6_pre_valid", 64'(ia.out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t6_in_ready", 64'(ia.in_ready), 64'(1));
        check("t6_out_valid", 64'(ia.out_valid), 64'(0));
        check("t6_opcode", 64'(ia.out_opcode), 64'(0));
        check("t6_address", 64'(ia.out_address), 64'(0));
        check("t6_age", 64'(ia.out_age), 64'(0));
        check("t6_count", 64'(count_a), 64'(0));
        check("t6_full", 64'(full_a), 64'(0));
        check("t6_empty", 64'(empty_a), 64'(1));
        @(negedge CPU_clk);
        rst_n = 1'b1;
        tick();
        check("t6_empty_after_release", 64'(empty_a), 64'(1));
        push_a(2'd1, 33'h500);
        check("t6_new_count", 64'(count_a), 64'(1));
        check("t6_new_age0", 64'(ia.out_age), 64'(0));
        check("t6_new_addr", 64'(ia.out_address), 64'(33'h500));
        tick();
        check("t6_new_age1", 64'(ia.out_age), 64'(1));

        // Flush wins over a concurrent push.
        flush_a = 1'b1;
        push_a(2'd2, 33'h600);
        flush_a = 1'b0;
        check("t7_count", 64'(count_a), 64'(0));
        check("t7_empty", 64'(empty_a), 64'(1));
        for (int j = 0; j < 110; j++) tick();
        check("t7_no_ghost", 64'(ia.out_valid), 64'(0));
        check("t7_still_empty", 64'(count_a), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
